spi_slave_rx: RTL and testbench

- SPI target (slave) block: receives frames clocked by an external SPI initiator and returns a preloaded word on SO.
- Oversamples SCK/CS/SI in the system clock domain. Mode 0 only (CPOL=0, CPHA=0), MSB first.
- Sits between the board SPI pins and the FPGA register/command logic. It is the target-side counterpart of the team's SPI initiator.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 26 ++
 rtl/spi_slave_rx.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target receiver: FSM states, mode and defaults.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        ABORT  = 2'd3
    } spi_state_e;

    localparam int unsigned SPI_MODE        = 0;     // CPOL=0, CPHA=0, MSB first
    localparam int unsigned SPI_DEF_WIDTH   = 32;
    localparam int unsigned SPI_DEF_TIMEOUT = 4096;
    localparam int unsigned SPI_CNT_W       = 7;     // width of rx_bits / bit counter

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a history flop for edge detection.
module spi_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sh_q;

    // Resetting to 0 means a CS held low across reset is never seen as a falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[1:0], din_i};
        end
    end

    assign dout_o = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 target: oversampled receive of up to WIDTH bits, preloaded word returned on SO.
// Optional inactivity abort enabled by defining SPI_SLAVE_TIMEOUT_EN.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH          = SPI_DEF_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = SPI_DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCK,
    input  logic             CS,
    input  logic             SI,
    output logic             SO,
    output logic             SO_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic [WIDTH-1:0] rx_data,
    output logic [6:0]       rx_bits,
    output logic             rx_valid,
    output logic             frame_err
);

    logic sck_rise, sck_fall;
    logic cs_rise, cs_fall;
    logic si_sync;
    logic sck_sync, cs_sync;
    logic timeout_hit;

    spi_state_e           state_q, state_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic [WIDTH-1:0]     tx_q, tx_d;
    logic [WIDTH-1:0]     rx_q, rx_d;
    logic [SPI_CNT_W-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     rx_data_q, rx_data_d;
    logic [SPI_CNT_W-1:0] rx_bits_q, rx_bits_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    spi_sync_edge u_sync_sck (
        .clk_i (clk),
        .rst_ni(rst),
        .din_i (SCK),
        .dout_o(sck_sync),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk_i (clk),
        .rst_ni(rst),
        .din_i (CS),
        .dout_o(cs_sync),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    spi_sync_edge u_sync_si (
        .clk_i (clk),
        .rst_ni(rst),
        .din_i (SI),
        .dout_o(si_sync),
        .rise_o(),
        .fall_o()
    );

`ifdef SPI_SLAVE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_q, idle_d;

    assign timeout_hit = (state_q == ACTIVE) && (idle_q == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        idle_d = idle_q;
        if (state_q != ACTIVE || sck_rise || sck_fall) begin
            idle_d = '0;
        end else if (!timeout_hit) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        rx_data_d   = rx_data_q;
        rx_bits_d   = rx_bits_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (tx_load) begin
            hold_d = tx_data;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_d    = tx_load ? tx_data : hold_q;
                    rx_d    = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // CS release takes priority over any SCK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d = (cnt_q != '0 && !ovf_q) ? DONE : ABORT;
                end else if (timeout_hit) begin
                    state_d = ABORT;
                end else begin
                    if (sck_rise) begin
                        if (cnt_q == SPI_CNT_W'(WIDTH)) begin
                            ovf_d = 1'b1;
                        end else begin
                            rx_d  = {rx_q[WIDTH-2:0], si_sync};
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        tx_d = {tx_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                rx_data_d  = rx_q;
                rx_bits_d  = cnt_q;
                rx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            ABORT: begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_bits_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            rx_data_q   <= rx_data_d;
            rx_bits_q   <= rx_bits_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign SO_oe     = (state_q == ACTIVE);
    assign SO        = SO_oe & tx_q[WIDTH-1];
    assign rx_data   = rx_data_q;
    assign rx_bits   = rx_bits_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table vectors, corner sequences and randomized frames.
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCK, CS, SI;
    logic        SO, SO_oe;
    logic [31:0] tx_data;
    logic        tx_load;
    logic [31:0] rx_data;
    logic [6:0]  rx_bits;
    logic        rx_valid, frame_err;

    always #5 clk = ~clk;

    spi_slave_rx #(.WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .SCK      (SCK),
        .CS       (CS),
        .SI       (SI),
        .SO       (SO),
        .SO_oe    (SO_oe),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_bits  (rx_bits),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;

    // Reference state: what the block should hold, tracked from the frames we send.
    logic [31:0] m_hold;
    logic [31:0] m_rx_data;
    logic [6:0]  m_rx_bits;

    always @(negedge clk) begin
        if (rx_valid)  n_valid++;
        if (frame_err) n_err++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic load_tx(input logic [31:0] v);
        @(posedge clk); #1;
        tx_data = v;
        tx_load = 1'b1;
        @(posedge clk); #1;
        tx_load = 1'b0;
        m_hold  = v;
    endtask

    // Initiator: CS low, nbits mode-0 SCK pulses at clk/8, MSB first; SO sampled on each rise.
    task automatic run_frame(input logic [63:0] mosi, input int nbits, input int load_at,
                             input logic [31:0] load_val, input int stop_after,
                             output logic [31:0] miso);
        miso = '0;
        @(posedge clk); #3;
        CS = 1'b0;
        #80;
        chk("so_oe_active", SO_oe, 1);
        for (int i = 0; i < nbits; i++) begin
            SI = mosi[nbits-1-i];
            #40;
            SCK  = 1'b1;
            miso = {miso[30:0], SO};
            if (i == load_at) load_tx(load_val);
            #40;
            SCK = 1'b0;
            if (i + 1 == stop_after) return;
        end
        #40;
    endtask

    task automatic finish_frame(output int lat);
        @(posedge clk); #1;
        CS  = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && (rx_valid || frame_err)) lat = k;
        end
    endtask

    task automatic xfer_check(input string nm, input logic [63:0] mosi, input int nbits,
                              input logic exp_ok, input logic [31:0] exp_data,
                              input logic [6:0] exp_bits, input logic chk_so,
                              input logic [31:0] exp_so);
        int v0, e0, lat;
        logic [31:0] so;
        v0 = n_valid;
        e0 = n_err;
        run_frame(mosi, nbits, -1, '0, -1, so);
        finish_frame(lat);
        chk({nm, "/latency"}, 64'(lat), 4);
        chk({nm, "/valid_pulses"}, 64'(n_valid - v0), exp_ok ? 1 : 0);
        chk({nm, "/err_pulses"}, 64'(n_err - e0), exp_ok ? 0 : 1);
        chk({nm, "/rx_data"}, rx_data, exp_data);
        chk({nm, "/rx_bits"}, rx_bits, exp_bits);
        chk({nm, "/so_oe_idle"}, SO_oe, 0);
        if (chk_so) chk({nm, "/so_word"}, so, exp_so);
    endtask

    typedef struct {
        logic [31:0] tx;
        logic [63:0] mosi;
        int          nbits;
        logic        ok;
        logic [31:0] data;
        logic [6:0]  bits;
        logic        chk_so;
        logic [31:0] so;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0, e0, lat, nb;
        logic [31:0] so, exp_data, exp_so;
        logic [63:0] mosi, mask;
        logic ok;

        tbl[0] = '{32'hA5C3_0F81, 64'h1234_5678, 32, 1'b1, 32'h1234_5678, 7'd32, 1'b1, 32'hA5C3_0F81};
        tbl[1] = '{32'hC300_0000, 64'h3C,        8,  1'b1, 32'h0000_003C, 7'd8,  1'b1, 32'h0000_00C3};
        tbl[2] = '{32'h0F0F_0F0F, 64'h1_89AB_CDEF, 33, 1'b0, 32'h0000_003C, 7'd8, 1'b0, 32'h0};
        tbl[3] = '{32'h1234_5678, 64'h0,         0,  1'b0, 32'h0000_003C, 7'd8,  1'b0, 32'h0};
        tbl[4] = '{32'h8000_0000, 64'h1,         1,  1'b1, 32'h0000_0001, 7'd1,  1'b1, 32'h0000_0001};
        tbl[5] = '{32'hDEAD_BEEF, 64'h1_5555,    17, 1'b1, 32'h0001_5555, 7'd17, 1'b1, 32'h0001_BD5B};

        rst = 1'b0; SCK = 1'b0; CS = 1'b1; SI = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        m_hold = '0; m_rx_data = '0; m_rx_bits = '0;
        #1;
        chk("reset/SO", SO, 0);
        chk("reset/SO_oe", SO_oe, 0);
        chk("reset/rx_data", rx_data, 0);
        chk("reset/rx_bits", rx_bits, 0);
        chk("reset/rx_valid", rx_valid, 0);
        chk("reset/frame_err", frame_err, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        repeat (6) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            load_tx(tbl[i].tx);
            xfer_check($sformatf("vec%0d", i), tbl[i].mosi, tbl[i].nbits, tbl[i].ok,
                       tbl[i].data, tbl[i].bits, tbl[i].chk_so, tbl[i].so);
        end
        m_rx_data = 32'h0001_5555;
        m_rx_bits = 7'd17;

        // tx_load mid-frame must not disturb the word already being shifted out.
        load_tx(32'h0);
        v0 = n_valid;
        run_frame(64'h0F1E_2D3C, 32, 5, 32'hFFFF_FFFF, -1, so);
        finish_frame(lat);
        chk("midload/so_word", so, 32'h0);
        chk("midload/valid_pulses", 64'(n_valid - v0), 1);
        chk("midload/rx_data", rx_data, 32'h0F1E_2D3C);
        xfer_check("midload_next", 64'h0000_00A5, 32, 1'b1, 32'h0000_00A5, 7'd32, 1'b1, 32'hFFFF_FFFF);

        // Reset in the middle of a frame, CS still low while reset is released.
        run_frame(64'hA_BCDE, 20, -1, '0, 12, so);
        #7 rst = 1'b0;
        #1;
        chk("midrst/SO_oe", SO_oe, 0);
        chk("midrst/SO", SO, 0);
        chk("midrst/rx_valid", rx_valid, 0);
        chk("midrst/frame_err", frame_err, 0);
        chk("midrst/rx_data", rx_data, 0);
        chk("midrst/rx_bits", rx_bits, 0);
        m_hold = '0; m_rx_data = '0; m_rx_bits = '0;
        @(posedge clk); #3 rst = 1'b1;
        v0 = n_valid; e0 = n_err;
        repeat (6) @(posedge clk);
        #2 CS = 1'b1;
        repeat (8) @(posedge clk);
        chk("midrst/no_pulse", 64'((n_valid - v0) + (n_err - e0)), 0);
        xfer_check("beef", 64'hBEEF, 16, 1'b1, 32'h0000_BEEF, 7'd16, 1'b1, 32'h0);
        m_rx_data = 32'h0000_BEEF;
        m_rx_bits = 7'd16;

        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 9))
                0:       nb = 33 + $urandom_range(0, 2);
                1:       nb = 0;
                default: nb = $urandom_range(1, 32);
            endcase
            if ($urandom_range(0, 1) == 1) load_tx($urandom());
            mosi = {$urandom(), $urandom()};
            ok   = (nb >= 1) && (nb <= 32);
            if (ok) begin
                mask     = (64'd1 << nb) - 64'd1;
                exp_data = 32'(mosi & mask);
                exp_so   = m_hold >> (32 - nb);
                xfer_check($sformatf("rnd%0d", r), mosi, nb, 1'b1, exp_data, 7'(nb), 1'b1, exp_so);
                m_rx_data = exp_data;
                m_rx_bits = 7'(nb);
            end else begin
                xfer_check($sformatf("rnd%0d", r), mosi, nb, 1'b0, m_rx_data, m_rx_bits, 1'b0, 32'h0);
            end
        end

        // Three bits then SCK stalls with CS still low.
        load_tx(32'h6000_0000);
        v0 = n_valid; e0 = n_err;
        run_frame(64'h5, 3, -1, '0, 3, so);
        chk("stall/so_word", so, 32'h3);
        repeat (100) @(posedge clk);
        #1;
`ifdef SPI_SLAVE_TIMEOUT_EN
        chk("timeout/err_pulses", 64'(n_err - e0), 1);
        chk("timeout/valid_pulses", 64'(n_valid - v0), 0);
        chk("timeout/rx_data_kept", rx_data, m_rx_data);
        finish_frame(lat);
        chk("timeout/late_cs_rise", 64'((n_valid - v0) + (n_err - e0)), 1);
`else
        chk("stall/no_pulse_yet", 64'((n_valid - v0) + (n_err - e0)), 0);
        finish_frame(lat);
        chk("stall/valid_pulses", 64'(n_valid - v0), 1);
        chk("stall/rx_bits", rx_bits, 3);
        chk("stall/rx_data", rx_data, 32'h5);
`endif
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
